// File: rtl/nibble_fetch_pkg.sv
// rtl/nibble_fetch_pkg.sv - shared types, constants and sizing helper for nibble_fetch_ctrl
//
// Purpose: nibble width, controller state encoding and a counter-width helper.
// Ports: none (package).

package nibble_fetch_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLD    = 3'd4
  } state_e;

  // Bits needed to hold values 0..max_val, never less than one bit.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/nibble_fetch_ctrl.sv
// rtl/nibble_fetch_ctrl.sv - request/settle/capture controller packing nibbles into a word
//
// Purpose: pulses ask_for_data, waits WAIT_CYCLES for the source to settle,
// samples data, packs NIBBLES nibbles MSB-first and offers the word over a
// valid/ready handshake.
// Ports:
//   sclk         in   system clock
//   rst          in   synchronous active-high reset
//   start        in   fetch one word (sampled in IDLE, and in HOLD on handshake)
//   data         in   4-bit nibble from the source
//   ask_for_data out  one-cycle request pulse to the source
//   word         out  assembled word, first nibble in the top bits
//   word_valid   out  word is held and valid
//   word_ready   in   consumer accepts word when word_valid && word_ready
//   busy         out  high whenever not IDLE

module nibble_fetch_ctrl
  import nibble_fetch_pkg::*;
#(
  parameter  int NIBBLES     = 4,
  parameter  int WAIT_CYCLES = 2,
  localparam int WORD_W      = NIB_W * NIBBLES
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  input  logic [NIB_W-1:0]  data,
  output logic              ask_for_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy
);

  localparam int NCW = cnt_width(NIBBLES);
  localparam int WCW = cnt_width(WAIT_CYCLES);

  // With WAIT_CYCLES = 0 the WAIT state is never entered, so the load value is moot.
  localparam logic [WCW-1:0] WAIT_LOAD  = (WAIT_CYCLES > 0) ? WCW'(WAIT_CYCLES - 1) : '0;
  localparam logic [NCW-1:0] LAST_NIB   = NCW'(NIBBLES - 1);

  state_e              state_q;
  logic [NCW-1:0]      nib_cnt_q;
  logic [WCW-1:0]      wait_q;
  logic [WORD_W-1:0]   shift_q;
  logic [WORD_W-1:0]   shift_d;
  logic                ask_q;
  logic                valid_q;
  logic                busy_q;

  // Shift the new nibble in at the bottom; older nibbles move toward the MSBs.
  generate
    if (NIBBLES == 1) begin : g_single
      assign shift_d = data;
    end else begin : g_multi
      assign shift_d = {shift_q[WORD_W-NIB_W-1:0], data};
    end
  endgenerate

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      nib_cnt_q <= '0;
      wait_q    <= '0;
      shift_q   <= '0;
      ask_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ask_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_REQ;
            ask_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (WAIT_CYCLES == 0) begin
            state_q <= ST_CAPTURE;
          end else begin
            state_q <= ST_WAIT;
            wait_q  <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (wait_q == '0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_q <= wait_q - WCW'(1);
          end
        end
        ST_CAPTURE: begin
          shift_q   <= shift_d;
          nib_cnt_q <= nib_cnt_q + NCW'(1);
          if (nib_cnt_q == LAST_NIB) begin
            state_q <= ST_HOLD;
            valid_q <= 1'b1;
          end else begin
            state_q <= ST_REQ;
            ask_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (word_ready) begin
            valid_q   <= 1'b0;
            nib_cnt_q <= '0;
            if (start) begin
              // Back-to-back word: request goes out in the cycle right after accept.
              state_q <= ST_REQ;
              ask_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ask_for_data = ask_q;
  assign word         = shift_q;
  assign word_valid   = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_nibble_fetch_ctrl.sv
// tb/tb_nibble_fetch_ctrl.sv - directed self-checking bench for nibble_fetch_ctrl

module tb_nibble_fetch_ctrl;

  logic        sclk = 1'b0;
  logic        rst  = 1'b1;

  // Default-parameter instance (NIBBLES=4, WAIT_CYCLES=2)
  logic        start = 1'b0;
  logic [3:0]  data  = 4'h0;
  logic        ask_for_data;
  logic [15:0] word;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        busy;

  // Minimal instance (NIBBLES=1, WAIT_CYCLES=0)
  logic        start2 = 1'b0;
  logic [3:0]  data2  = 4'h0;
  logic        ask2;
  logic [3:0]  word2;
  logic        valid2;
  logic        ready2 = 1'b0;
  logic        busy2;

  int errors = 0;
  int checks = 0;

  // Source model for the default instance: each request edge presents the next table entry.
  logic [3:0] src [0:7];
  logic       src_clr = 1'b0;
  int         src_idx = 0;

  nibble_fetch_ctrl dut (
    .sclk(sclk), .rst(rst), .start(start), .data(data),
    .ask_for_data(ask_for_data), .word(word), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy)
  );

  nibble_fetch_ctrl #(.NIBBLES(1), .WAIT_CYCLES(0)) dut2 (
    .sclk(sclk), .rst(rst), .start(start2), .data(data2),
    .ask_for_data(ask2), .word(word2), .word_valid(valid2),
    .word_ready(ready2), .busy(busy2)
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk) begin
    if (src_clr) begin
      src_idx <= 0;
    end else if (ask_for_data) begin
      data    <= src[src_idx % 8];
      src_idx <= src_idx + 1;
    end
  end

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic load_src(input logic [31:0] nibs);
    for (int i = 0; i < 8; i++) src[i] = nibs[31-4*i -: 4];
    src_clr = 1'b1;
    tick();
    src_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({ask_for_data, word_valid, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got ask/valid/busy=%b expected 000", {ask_for_data, word_valid, busy});
    end
    checks++;
    if (word !== 16'h0000) begin
      errors++;
      $display("FAIL reset_word: got %h expected 0000", word);
    end
    checks++;
    if ({ask2, valid2, busy2, word2} !== 7'b0) begin
      errors++;
      $display("FAIL reset_dut2: got %b expected 0000000", {ask2, valid2, busy2, word2});
    end
    rst = 1'b0;
    tick();
  endtask

  // Default timing: requests after edges 0,4,8,12, word valid after edge 16.
  task automatic test_basic();
    load_src(32'hABCD_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 0; e <= 16; e++) begin
      if (e != 0) tick();
      checks++;
      if (ask_for_data !== ((e % 4 == 0) && (e < 16))) begin
        errors++;
        $display("FAIL basic_ask e=%0d: got %b expected %b", e, ask_for_data, ((e % 4 == 0) && (e < 16)));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_busy e=%0d: got %b expected 1", e, busy);
      end
      checks++;
      if (word_valid !== (e == 16)) begin
        errors++;
        $display("FAIL basic_valid e=%0d: got %b expected %b", e, word_valid, (e == 16));
      end
    end
    checks++;
    if (word !== 16'hABCD) begin
      errors++;
      $display("FAIL basic_word: got %h expected abcd", word);
    end
  endtask

  // Stall in HOLD: word stays put, no requests, then accept returns to IDLE.
  task automatic test_hold_stall();
    word_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({word_valid, ask_for_data, busy, word} !== {3'b101, 16'hABCD}) begin
        errors++;
        $display("FAIL stall i=%0d: got valid/ask/busy=%b word=%h expected 101 abcd",
                 i, {word_valid, ask_for_data, busy}, word);
      end
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    checks++;
    if ({word_valid, busy, ask_for_data} !== 3'b000) begin
      errors++;
      $display("FAIL stall_accept: got valid/busy/ask=%b expected 000", {word_valid, busy, ask_for_data});
    end
    checks++;
    if (word !== 16'hABCD) begin
      errors++;
      $display("FAIL stall_word_after: got %h expected abcd", word);
    end
  endtask

  // WAIT_CYCLES=0, NIBBLES=1: request after edge 0, capture at edge 2.
  task automatic test_zero_wait();
    data2  = 4'h5;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    checks++;
    if ({ask2, valid2, busy2} !== 3'b101) begin
      errors++;
      $display("FAIL zw_e0: got ask/valid/busy=%b expected 101", {ask2, valid2, busy2});
    end
    tick();
    checks++;
    if ({ask2, valid2, busy2} !== 3'b001) begin
      errors++;
      $display("FAIL zw_e1: got ask/valid/busy=%b expected 001", {ask2, valid2, busy2});
    end
    tick();
    checks++;
    if ({ask2, valid2, busy2, word2} !== {3'b011, 4'h5}) begin
      errors++;
      $display("FAIL zw_e2: got ask/valid/busy=%b word=%h expected 011 5", {ask2, valid2, busy2}, word2);
    end
    ready2 = 1'b1;
    tick();
    ready2 = 1'b0;
    checks++;
    if ({valid2, busy2} !== 2'b00) begin
      errors++;
      $display("FAIL zw_accept: got valid/busy=%b expected 00", {valid2, busy2});
    end
  endtask

  // start and word_ready held high: accept at edge 17, next word valid at edge 33.
  task automatic test_back_to_back();
    int asks;
    asks = 0;
    load_src(32'h1234_5678);
    start      = 1'b1;
    word_ready = 1'b1;
    tick();
    if (ask_for_data) asks++;
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (ask_for_data) asks++;
      if (e == 16) begin
        checks++;
        if ({word_valid, word} !== {1'b1, 16'h1234}) begin
          errors++;
          $display("FAIL b2b_first: got valid=%b word=%h expected 1 1234", word_valid, word);
        end
      end
      if (e == 17) begin
        checks++;
        if ({word_valid, ask_for_data, busy} !== 3'b011) begin
          errors++;
          $display("FAIL b2b_accept: got valid/ask/busy=%b expected 011", {word_valid, ask_for_data, busy});
        end
      end
      if (e == 32) begin
        checks++;
        if (word_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_early_valid: got %b expected 0", word_valid);
        end
      end
    end
    checks++;
    if ({word_valid, word} !== {1'b1, 16'h5678}) begin
      errors++;
      $display("FAIL b2b_second: got valid=%b word=%h expected 1 5678", word_valid, word);
    end
    checks++;
    if (asks != 8) begin
      errors++;
      $display("FAIL b2b_req_count: got %0d expected 8", asks);
    end
    start = 1'b0;
    tick();
    word_ready = 1'b0;
    checks++;
    if ({word_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_idle: got valid/busy=%b expected 00", {word_valid, busy});
    end
  endtask

  // Reset at edge 6 (with start high to show reset wins), then a clean fetch.
  task automatic test_reset_mid();
    load_src(32'hEEEE_0000);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 5; e++) tick();
    rst   = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({ask_for_data, word_valid, busy, word} !== 19'b0) begin
        errors++;
        $display("FAIL rst_mid i=%0d: got ask/valid/busy=%b word=%h expected 000 0000",
                 i, {ask_for_data, word_valid, busy}, word);
      end
    end
    rst   = 1'b0;
    start = 1'b0;
    load_src(32'h3C5A_0000);
    checks++;
    if ({ask_for_data, busy} !== 2'b00) begin
      errors++;
      $display("FAIL rst_idle: got ask/busy=%b expected 00", {ask_for_data, busy});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 16; e++) tick();
    checks++;
    if ({word_valid, word} !== {1'b1, 16'h3C5A}) begin
      errors++;
      $display("FAIL rst_refetch: got valid=%b word=%h expected 1 3c5a", word_valid, word);
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  // start toggling during REQ/WAIT/CAPTURE must not add requests or words.
  task automatic test_start_ignored();
    int asks;
    asks = 0;
    load_src(32'h7123_0000);
    start = 1'b1;
    tick();
    if (ask_for_data) asks++;
    for (int e = 1; e <= 16; e++) begin
      start = (e % 2 == 1) && (e < 16);
      tick();
      if (ask_for_data) asks++;
    end
    start = 1'b0;
    checks++;
    if (asks != 4) begin
      errors++;
      $display("FAIL ign_req_count: got %0d expected 4", asks);
    end
    checks++;
    if ({word_valid, word} !== {1'b1, 16'h7123}) begin
      errors++;
      $display("FAIL ign_word: got valid=%b word=%h expected 1 7123", word_valid, word);
    end
    tick();
    checks++;
    if ({word_valid, ask_for_data} !== 2'b10) begin
      errors++;
      $display("FAIL ign_hold: got valid/ask=%b expected 10", {word_valid, ask_for_data});
    end
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_stall();
    test_zero_wait();
    test_back_to_back();
    test_reset_mid();
    test_start_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
